// File: rtl/kyber_pkg.sv
// Shared Kyber constants and coefficient/product types for mul_k and red_K.
// Also holds the pipeline stage payload layouts.
package kyber_pkg;
   localparam int KYBER_Q = 3329;
   localparam int KYBER_N = 256;
   localparam int COEF_W  = 12;
   localparam int PROD_W  = 2 * COEF_W;

   typedef logic [COEF_W-1:0] coef_t;
   typedef logic [PROD_W-1:0] prod_t;
   typedef logic [7:0]        idx_t;

   typedef struct packed {
      coef_t a;
      coef_t b;
      idx_t  idx;
      logic  last;
   } s1_t;

   typedef struct packed {
      prod_t p;
      idx_t  idx;
      logic  last;
   } s2_t;
endpackage

// File: rtl/pipe_reg.sv
// One-entry valid/ready pipeline slice. The slice may load whenever it is
// empty or its current entry is leaving downstream.
module pipe_reg #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);
   assign in_ready = !out_valid | out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (clr) begin
         out_valid <= 1'b0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
   end
endmodule

// File: rtl/mul_k.sv
// Two-stage Kyber coefficient multiplier feeding red_K: S1 captures operands,
// S2 captures the exact 24-bit product. Tracks coefficient index and range errors.
module mul_k
   import kyber_pkg::*;
#(
   parameter int Q = KYBER_Q,
   parameter int N = KYBER_N,
   parameter int W = COEF_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_product,
   output logic           out_last,
   output logic [7:0]     out_idx,
   output logic           err
);
   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);
   localparam logic [W-1:0] QW = W'(Q);

   logic [CNT_W-1:0] cnt;
   logic             s1_adv, s1_valid, s2_adv, s2_valid, xfer;
   s1_t              s1_d, s1_q;
   s2_t              s2_d, s2_q;

   // rst_n gates in_ready so nothing is offered as accepted while held in reset
   assign in_ready = s1_adv & !clr & rst_n;
   assign xfer     = in_valid & in_ready;

   always_comb begin
      s1_d      = '0;
      s1_d.a    = in_a;
      s1_d.b    = in_b;
      s1_d.idx  = idx_t'(cnt);
      s1_d.last = (cnt == CNT_MAX);
   end

   always_comb begin
      s2_d      = '0;
      s2_d.p    = prod_t'(s1_q.a) * prod_t'(s1_q.b);
      s2_d.idx  = s1_q.idx;
      s2_d.last = s1_q.last;
   end

   pipe_reg #(.DW($bits(s1_t))) u_s1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (xfer),
      .in_ready  (s1_adv),
      .in_data   (s1_d),
      .out_valid (s1_valid),
      .out_ready (s2_adv),
      .out_data  (s1_q)
   );

   pipe_reg #(.DW($bits(s2_t))) u_s2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (s1_valid),
      .in_ready  (s2_adv),
      .in_data   (s2_d),
      .out_valid (s2_valid),
      .out_ready (out_ready),
      .out_data  (s2_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (xfer) begin
         cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
         // out-of-range operands still flow through; only the flag records it
         if (in_a >= QW || in_b >= QW) err <= 1'b1;
      end
   end

   assign out_valid   = s2_valid;
   assign out_product = s2_q.p;
   assign out_idx     = s2_q.idx;
   assign out_last    = s2_q.last;
endmodule
